// File: rtl/vru_pkg.sv
// Shared types for the side-road vehicle request unit: FSM states and light codes
// common to the traffic light controller.
package vru_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2
  } vru_state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

endpackage

// File: rtl/sensor_debounce.sv
// Loop-detector conditioning: 2-flop synchronizer, consecutive-sample debounce filter
// and a registered one-cycle pulse on each rising edge of the filtered level.
module sensor_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [DW-1:0] run_q;
  logic          at_limit;

  assign at_limit = (run_q == DW'(DEB_CYCLES - 1));

  // run_q counts consecutive synchronized samples that disagree with the filtered level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      run_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= sensor_raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 != level) begin
        if (at_limit) begin
          level <= sync_q2;
          rise  <= sync_q2;
          run_q <= '0;
        end else begin
          run_q <= run_q + DW'(1);
        end
      end else begin
        run_q <= '0;
      end
    end
  end

endmodule

// File: rtl/vehicle_request_unit.sv
// Side-road vehicle request unit: counts debounced arrivals, raises C toward the light
// controller and drains the count while the side road is green.
// Optional stuck-sensor detection is enabled with macro VRU_STUCK_DETECT_EN.
module vehicle_request_unit
  import vru_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_raw,
  input  logic [1:0]       nitkRoadLights,
  output logic             C,
  output logic [CNT_W-1:0] car_count,
  output logic             sensor_fault
);

  localparam int unsigned TW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  vru_state_t       state_q, state_d;
  logic [TW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             c_q, c_d;
  logic             level;
  logic             arrival;
  logic             green;
  logic             tick;
  logic             fault_d;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .level      (level),
    .rise       (arrival)
  );

  assign green = (nitkRoadLights == LIGHT_GREEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      count_q <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      c_q     <= c_d;
    end
  end

  // Next state, drain timer and vehicle count; codes other than green count as red
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    tick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arrival) state_d = WAIT;
      end
      WAIT: begin
        if (green) begin
          state_d = SERVE;
          drain_d = '0;
        end
      end
      SERVE: begin
        if (!green) begin
          state_d = WAIT;
          drain_d = '0;
        end else if (drain_q == TW'(DRAIN_CYCLES - 1)) begin
          tick    = 1'b1;
          drain_d = '0;
        end else begin
          drain_d = drain_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A departure and an arrival in the same cycle cancel out
    if (arrival && !tick) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (tick && !arrival) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end

    if (state_q == SERVE && green && count_d == '0) begin
      state_d = IDLE;
      drain_d = '0;
    end

    c_d = (state_d != IDLE) | fault_d;
  end

`ifdef VRU_STUCK_DETECT_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

  logic [SW-1:0] stuck_q;
  logic          fault_q;
  logic          stuck_hit;

  assign stuck_hit = level && (stuck_q == SW'(STUCK_CYCLES - 1));
  assign fault_d   = fault_q | stuck_hit;

  // Consecutive filtered-high cycles; the fault flag is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (!level) stuck_q <= '0;
      else if (stuck_q != SW'(STUCK_CYCLES)) stuck_q <= stuck_q + SW'(1);
      if (stuck_hit) fault_q <= 1'b1;
    end
  end

  assign sensor_fault = fault_q;
`else
  logic unused_level;

  assign unused_level = level;
  assign fault_d      = 1'b0;
  assign sensor_fault = 1'b0;
`endif

  assign C         = c_q;
  assign car_count = count_q;

endmodule

// File: tb/tb_vehicle_request_unit.sv
// Scoreboard bench for vehicle_request_unit: a window-based reference model predicts
// C / car_count / sensor_fault every cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vehicle_request_unit;

  localparam int DEB   = 4;
  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int STUCK = 64;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          raw;
  logic [1:0]    lights;
  logic          C;
  logic [CW-1:0] car_count;
  logic          sensor_fault;

  vehicle_request_unit #(
    .DEB_CYCLES  (DEB),
    .DRAIN_CYCLES(DRAIN),
    .CNT_W       (CW),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_raw    (raw),
    .nitkRoadLights(lights),
    .C             (C),
    .car_count     (car_count),
    .sensor_fault  (sensor_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit c;
    int cnt;
    bit fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: raw-sample history, filtered level, pending arrival, count, serving
  bit m_hist[0:DEB];
  bit m_lvl;
  bit m_arr;
  bit m_serving;
  int m_cnt;
  int m_tmr;
  bit m_fault;
`ifdef VRU_STUCK_DETECT_EN
  int m_hi;
`endif

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i <= DEB; i++) m_hist[i] = 1'b0;
    m_lvl = 0; m_arr = 0; m_serving = 0; m_cnt = 0; m_tmr = 0; m_fault = 0;
`ifdef VRU_STUCK_DETECT_EN
    m_hi = 0;
`endif
  endfunction

  function automatic void model_edge(bit r, bit [1:0] l);
    bit green = (l == 2'b10);
    bit tick = 0;
    bit all_diff = 1;
`ifdef VRU_STUCK_DETECT_EN
    if (m_lvl) begin
      if (m_hi < STUCK) m_hi++;
    end else m_hi = 0;
    if (m_hi == STUCK) m_fault = 1;
`endif
    if (!m_serving) begin
      if (m_cnt > 0 && green) begin
        m_serving = 1;
        m_tmr = 0;
      end
    end else if (!green) begin
      m_serving = 0;
      m_tmr = 0;
    end else if (m_tmr == DRAIN - 1) begin
      tick = 1;
      m_tmr = 0;
    end else begin
      m_tmr++;
    end
    if (m_arr && tick) begin
      // departure and arrival cancel
    end else if (m_arr) begin
      if (m_cnt < MAXC) m_cnt++;
    end else if (tick && m_cnt > 0) begin
      m_cnt--;
    end
    if (m_serving && m_cnt == 0) m_serving = 0;
    // Synchronized sample seen at this edge is raw from two edges ago (m_hist[1])
    for (int i = 1; i <= DEB; i++) if (m_hist[i] == m_lvl) all_diff = 0;
    m_arr = all_diff && !m_lvl;
    if (all_diff) m_lvl = !m_lvl;
    for (int i = DEB; i >= 1; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = r;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (!reset) model_clear();
    else model_edge(raw, lights);
    e.c = (m_cnt > 0) || m_fault;
    e.cnt = m_cnt;
    e.fault = m_fault;
    sb.push_back(e);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    steps(n);
    reset = 1'b1;
  endtask

  task automatic arrive();
    raw = 1'b1;
    steps(8);
    raw = 1'b0;
    steps(8);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("mon_C", int'(C), int'(mon_e.c));
      chk("mon_car_count", int'(car_count), mon_e.cnt);
      chk("mon_sensor_fault", int'(sensor_fault), int'(mon_e.fault));
    end
  end

  initial begin
    bit got;
    int hold;
    reset  = 1'b0;
    raw    = 1'b1;
    lights = 2'b00;
    model_clear();

    // Reset held with sensor high, then release: one arrival within 7 edges
    steps(5);
    chk("rst_C", int'(C), 0);
    chk("rst_car_count", int'(car_count), 0);
    reset = 1'b1;
    got = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (C) begin
        got = 1;
        break;
      end
    end
    chk("rst_release_C_within_7", int'(got), 1);
    chk("rst_release_count", int'(car_count), 1);
    raw = 1'b0;
    steps(10);

    // Short 3-cycle pulse is filtered out
    do_reset(2);
    raw = 1'b1;
    steps(3);
    raw = 1'b0;
    steps(12);
    chk("short_pulse_count", int'(car_count), 0);
    chk("short_pulse_C", int'(C), 0);

    // Three arrivals then green: 3,2,1,0 every 3 cycles, C falls on 9th SERVE cycle
    for (int i = 0; i < 3; i++) arrive();
    chk("three_arrivals", int'(car_count), 3);
    lights = 2'b10;
    steps(9);
    chk("drain_before_last_count", int'(car_count), 1);
    chk("drain_before_last_C", int'(C), 1);
    step();
    chk("drain_done_count", int'(car_count), 0);
    chk("drain_done_C", int'(C), 0);
    lights = 2'b00;
    steps(4);

    // Saturation at 15, then arrival coinciding with a drain tick
    for (int i = 0; i < 17; i++) arrive();
    chk("sat_count", int'(car_count), MAXC);
    chk("sat_C", int'(C), 1);
    raw = 1'b1;
    steps(3);
    lights = 2'b10;
    steps(4);
    chk("arrival_with_drain", int'(car_count), MAXC);
    raw = 1'b0;
    steps(52);
    chk("sat_drained", int'(car_count), 0);
    lights = 2'b11;
    steps(4);

    // Lights leave green with two cars waiting
    for (int i = 0; i < 3; i++) arrive();
    lights = 2'b10;
    steps(4);
    chk("serve_count2", int'(car_count), 2);
    lights = 2'b01;
    steps(5);
    chk("yellow_hold_count", int'(car_count), 2);
    chk("yellow_hold_C", int'(C), 1);
    lights = 2'b10;
    steps(10);
    lights = 2'b00;

    // Randomized sensor and light traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        raw  = ~raw;
        hold = $urandom_range(12, 1);
      end
      hold--;
      if ($urandom_range(9, 0) == 0) lights = 2'($urandom_range(3, 0));
      step();
    end
    raw = 1'b0;
    lights = 2'b00;
    steps(10);

`ifdef VRU_STUCK_DETECT_EN
    // Stuck sensor: sticky fault forces C even after the count drains
    do_reset(2);
    raw = 1'b1;
    steps(80);
    chk("stuck_fault", int'(sensor_fault), 1);
    chk("stuck_C", int'(C), 1);
    raw = 1'b0;
    lights = 2'b10;
    steps(20);
    chk("stuck_drained_count", int'(car_count), 0);
    chk("stuck_drained_C", int'(C), 1);
    chk("stuck_sticky", int'(sensor_fault), 1);
    lights = 2'b00;
    do_reset(2);
    chk("stuck_cleared_fault", int'(sensor_fault), 0);
    chk("stuck_cleared_C", int'(C), 0);
    steps(4);
`endif

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vehicle_request_unit.md
VEHICLE_REQUEST_UNIT -- requirements
Module: vehicle_request_unit

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed to change the filtered sensor level.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: green cycles per departing vehicle.
REQ-003 SHALL have parameter CNT_W, default 4: width of the waiting-vehicle counter.
REQ-004 SHALL have parameter STUCK_CYCLES, default 64: filtered-high cycles before a stuck-sensor fault.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sensor_raw  input  1  asynchronous side-road loop detector, high while a vehicle is over the loop.
REQ-008 SHALL have port nitkRoadLights  input  2  side-road light code from the controller: 00 red, 01 yellow, 10 green.
REQ-009 SHALL have port C  output  1  vehicle-waiting request to the traffic light controller.
REQ-010 SHALL have port car_count  output  CNT_W  vehicles waiting or being served.
REQ-011 SHALL have port sensor_fault  output  1  sticky stuck-sensor indication.

Function
REQ-012 SHALL pass sensor_raw through a 2-flop synchronizer before any other use.
REQ-013 SHALL change the filtered level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; shorter pulses are ignored.
REQ-014 SHALL count one arrival on each 0->1 transition of the filtered level.
REQ-015 SHALL implement FSM states IDLE (C=0), WAIT (C=1), SERVE (C=1), with C driven from a register.
REQ-016 IDLE -> WAIT on arrival; C SHALL be 1 no later than 2+DEB_CYCLES+1 clock edges after sensor_raw rises and stays high.
REQ-017 WAIT -> SERVE when nitkRoadLights==10.
REQ-018 In SERVE, car_count SHALL decrement by 1 every DRAIN_CYCLES cycles; the drain timer is cleared on SERVE entry.
REQ-019 SERVE -> IDLE on the cycle car_count becomes 0; C=0 on that cycle.
REQ-020 SERVE -> WAIT if nitkRoadLights leaves 10 while car_count>0; C stays 1 and the drain timer is cleared.
REQ-021 car_count SHALL saturate at 2^CNT_W-1 on arrival and never decrement below 0.
REQ-022 Arrival and drain in the same cycle SHALL leave car_count unchanged.
REQ-023 Codes 11 on nitkRoadLights SHALL be treated as red.

Reset
REQ-024 reset low SHALL asynchronously force IDLE, C=0, car_count=0, sensor_fault=0, synchronizer, filter, drain and stuck counters to 0.
REQ-025 Reset mid-SERVE SHALL discard all waiting vehicles; after release a still-high sensor SHALL count as one new arrival once debounced.

Configuration
REQ-026 With macro VRU_STUCK_DETECT_EN defined, the filtered level high for STUCK_CYCLES consecutive cycles SHALL set sensor_fault (sticky until reset) and force C=1 in every state.
REQ-027 Without VRU_STUCK_DETECT_EN, sensor_fault SHALL be tied 0 and no stuck counter SHALL exist.

Structure
REQ-028 Package vru_pkg SHALL hold the FSM state type and the light-code constants LIGHT_RED=00, LIGHT_YELLOW=01, LIGHT_GREEN=10, shared with the controller.
REQ-029 Sub-module sensor_debounce SHALL contain the synchronizer, filter and rising-edge pulse; the FSM, counter and stuck detection stay in vehicle_request_unit.

Verification
REQ-030 Hold reset low with sensor_raw=1 -> C=0, car_count=0; release -> car_count=1, C=1 within 7 edges.
REQ-031 sensor_raw high for 3 cycles (DEB_CYCLES=4) -> car_count stays 0, C stays 0.
REQ-032 Three clean arrivals, then nitkRoadLights=10 -> car_count 3,2,1,0 at 3-cycle spacing; C falls at the 9th SERVE cycle.
REQ-033 17 arrivals with lights red -> car_count=15, C=1; an arrival coinciding with a drain tick in SERVE -> count unchanged.
REQ-034 car_count=2 in SERVE, lights change to 01 -> state WAIT, C stays 1, car_count=2.
REQ-035 With VRU_STUCK_DETECT_EN, sensor_raw held high for 70 cycles -> sensor_fault=1, C=1 even at car_count=0; held until reset.
